// File: rtl/vote_tally_ctrl.sv
// vote_tally_ctrl: single owner of the vote-count RAM port.
// Takes ballots over a valid/ready handshake and read-modify-writes the count
// for the addressed candidate. The count saturates at all-ones and never wraps.
// On request it clears the RAM, or scans every count, streams the counts out
// and reports the winner.
//
// Ports
//   clk, reset                    clock; asynchronous active-high reset
//   vote_valid/vote_cand          ballot request and candidate index
//   vote_ready                    ballot can be accepted this cycle
//   vote_done/vote_err/vote_sat   ballot outcome pulses
//   clear_req, result_req         zero all counts / scan all counts
//   ram_*                         RAM port (combinational read data in)
//   res_valid/res_cand/res_count  streamed counts, one beat per candidate
//   result_done                   pulse on the final stream beat
//   win_valid/win_cand/win_count/win_tie  winner of the most recent scan
module vote_tally_ctrl #(
  parameter int unsigned NUM_CAND = 16,
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vote_valid,
  input  logic [3:0]        vote_cand,
  output logic              vote_ready,
  output logic              vote_done,
  output logic              vote_err,
  output logic              vote_sat,
  input  logic              clear_req,
  input  logic              result_req,
  output logic              ram_wr_en,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              res_valid,
  output logic [3:0]        res_cand,
  output logic [DATA_W-1:0] res_count,
  output logic              result_done,
  output logic              win_valid,
  output logic [3:0]        win_cand,
  output logic [DATA_W-1:0] win_count,
  output logic              win_tie
);

  typedef enum logic [2:0] {
    StIdle,
    StVread,
    StVwrite,
    StClear,
    StScan,
    StDone
  } state_e;

  localparam logic [3:0] LastIdx    = 4'(NUM_CAND - 1);
  localparam logic [4:0] NumCandExt = 5'(NUM_CAND);

  state_e              state_q, state_d;
  logic                alive_q, alive_d;
  logic [3:0]          cand_q, cand_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic                vote_err_q, vote_err_d;
  logic [3:0]          scan_idx_q, scan_idx_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [3:0]          idx_q, idx_d;
  logic                tie_q, tie_d;
  logic                res_valid_q, res_valid_d;
  logic [3:0]          res_cand_q, res_cand_d;
  logic [DATA_W-1:0]   res_count_q, res_count_d;
  logic                win_valid_q, win_valid_d;
  logic [3:0]          win_cand_q, win_cand_d;
  logic [DATA_W-1:0]   win_count_q, win_count_d;
  logic                win_tie_q, win_tie_d;

  logic                cand_bad;
  logic                cnt_sat;
  logic [DATA_W-1:0]   cnt_inc;
  logic [DATA_W-1:0]   scan_max;
  logic [3:0]          scan_idx;
  logic                scan_tie;

  assign cand_bad = ({1'b0, vote_cand} >= NumCandExt);
  assign cnt_sat  = (cnt_q == {DATA_W{1'b1}});
  assign cnt_inc  = cnt_sat ? cnt_q : cnt_q + DATA_W'(1);

  // alive_q keeps vote_ready low while reset is held, even though the state is already idle.
  assign vote_ready = alive_q && (state_q == StIdle) && !clear_req && !result_req;

  // Running maximum including the count currently on the read port.
  // A strict greater-than keeps the lowest index on ties.
  always_comb begin
    scan_max = max_q;
    scan_idx = idx_q;
    scan_tie = tie_q;
    if ((scan_idx_q == 4'd0) || (ram_data_out > max_q)) begin
      scan_max = ram_data_out;
      scan_idx = scan_idx_q;
      scan_tie = 1'b0;
    end else if (ram_data_out == max_q) begin
      scan_tie = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    alive_d     = 1'b1;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    vote_err_d  = 1'b0;
    scan_idx_d  = scan_idx_q;
    max_d       = max_q;
    idx_d       = idx_q;
    tie_d       = tie_q;
    res_valid_d = res_valid_q;
    res_cand_d  = res_cand_q;
    res_count_d = res_count_q;
    win_valid_d = win_valid_q;
    win_cand_d  = win_cand_q;
    win_count_d = win_count_q;
    win_tie_d   = win_tie_q;

    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d     = StClear;
          win_valid_d = 1'b0;
          win_cand_d  = '0;
          win_count_d = '0;
          win_tie_d   = 1'b0;
        end else if (result_req) begin
          state_d     = StScan;
          scan_idx_d  = '0;
          win_valid_d = 1'b0;
        end else if (vote_valid && vote_ready) begin
          if (cand_bad) begin
            vote_err_d = 1'b1;
          end else begin
            cand_d  = vote_cand;
            state_d = StVread;
          end
        end
      end
      StVread: begin
        cnt_d   = ram_data_out;
        state_d = StVwrite;
      end
      StVwrite: begin
        state_d = StIdle;
      end
      StClear: begin
        win_valid_d = 1'b0;
        win_cand_d  = '0;
        win_count_d = '0;
        win_tie_d   = 1'b0;
        state_d     = StIdle;
      end
      StScan: begin
        res_valid_d = 1'b1;
        res_cand_d  = scan_idx_q;
        res_count_d = ram_data_out;
        max_d       = scan_max;
        idx_d       = scan_idx;
        tie_d       = scan_tie;
        if (scan_idx_q == LastIdx) begin
          // Winner is published together with the last stream beat.
          state_d     = StDone;
          win_valid_d = 1'b1;
          win_cand_d  = scan_idx;
          win_count_d = scan_max;
          win_tie_d   = scan_tie;
        end else begin
          scan_idx_d = scan_idx_q + 4'd1;
        end
      end
      StDone: begin
        res_valid_d = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      alive_q     <= 1'b0;
      cand_q      <= '0;
      cnt_q       <= '0;
      vote_err_q  <= 1'b0;
      scan_idx_q  <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      tie_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_cand_q  <= '0;
      res_count_q <= '0;
      win_valid_q <= 1'b0;
      win_cand_q  <= '0;
      win_count_q <= '0;
      win_tie_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      vote_err_q  <= vote_err_d;
      scan_idx_q  <= scan_idx_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      tie_q       <= tie_d;
      res_valid_q <= res_valid_d;
      res_cand_q  <= res_cand_d;
      res_count_q <= res_count_d;
      win_valid_q <= win_valid_d;
      win_cand_q  <= win_cand_d;
      win_count_q <= win_count_d;
      win_tie_q   <= win_tie_d;
    end
  end

  // RAM port and ballot pulses decode directly from the registered state,
  // so they are all zero while reset holds the state idle.
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_reset   = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    vote_done   = 1'b0;
    vote_sat    = 1'b0;
    result_done = 1'b0;
    unique case (state_q)
      StVread: begin
        ram_addr = ADDR_W'(cand_q);
      end
      StVwrite: begin
        ram_wr_en   = 1'b1;
        ram_addr    = ADDR_W'(cand_q);
        ram_data_in = cnt_inc;
        vote_done   = 1'b1;
        vote_sat    = cnt_sat;
      end
      StClear: begin
        ram_reset = 1'b1;
      end
      StScan: begin
        ram_addr = ADDR_W'(scan_idx_q);
      end
      StDone: begin
        result_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign vote_err  = vote_err_q;
  assign res_valid = res_valid_q;
  assign res_cand  = res_cand_q;
  assign res_count = res_count_q;
  assign win_valid = win_valid_q;
  assign win_cand  = win_cand_q;
  assign win_count = win_count_q;
  assign win_tie   = win_tie_q;

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Directed testbench for vote_tally_ctrl with a behavioural 32x10 RAM
// (synchronous write and clear, combinational read) and a count model.
module tb_vote_tally_ctrl;

  localparam int unsigned NC = 12;
  localparam int unsigned DW = 10;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset;
  logic          vote_valid;
  logic [3:0]    vote_cand;
  logic          vote_ready;
  logic          vote_done;
  logic          vote_err;
  logic          vote_sat;
  logic          clear_req;
  logic          result_req;
  logic          ram_wr_en;
  logic          ram_reset;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          res_valid;
  logic [3:0]    res_cand;
  logic [DW-1:0] res_count;
  logic          result_done;
  logic          win_valid;
  logic [3:0]    win_cand;
  logic [DW-1:0] win_count;
  logic          win_tie;

  int checks;
  int errors;

  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] exp_cnt [0:15];

  vote_tally_ctrl #(
    .NUM_CAND(NC),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vote_valid  (vote_valid),
    .vote_cand   (vote_cand),
    .vote_ready  (vote_ready),
    .vote_done   (vote_done),
    .vote_err    (vote_err),
    .vote_sat    (vote_sat),
    .clear_req   (clear_req),
    .result_req  (result_req),
    .ram_wr_en   (ram_wr_en),
    .ram_reset   (ram_reset),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .res_valid   (res_valid),
    .res_cand    (res_cand),
    .res_count   (res_count),
    .result_done (result_done),
    .win_valid   (win_valid),
    .win_cand    (win_cand),
    .win_count   (win_count),
    .win_tie     (win_tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_data_in;
    end
  end
  assign ram_data_out = mem[ram_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, vote_ready, 0);
    chk({tag, "_done"}, vote_done, 0);
    chk({tag, "_err"}, vote_err, 0);
    chk({tag, "_sat"}, vote_sat, 0);
    chk({tag, "_wr_en"}, ram_wr_en, 0);
    chk({tag, "_ram_reset"}, ram_reset, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_data_in, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_cand"}, res_cand, 0);
    chk({tag, "_res_count"}, res_count, 0);
    chk({tag, "_result_done"}, result_done, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_cand"}, win_cand, 0);
    chk({tag, "_win_count"}, win_count, 0);
    chk({tag, "_win_tie"}, win_tie, 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_cnt[i] = '0;
  endtask

  // Called at #1 after an edge with the DUT idle.
  task automatic cast_vote(input logic [3:0] c);
    logic          sat;
    logic [DW-1:0] nv;
    sat = (exp_cnt[c] == 10'h3FF);
    nv  = sat ? exp_cnt[c] : exp_cnt[c] + 10'd1;
    chk("vote_ready_idle", vote_ready, 1);
    vote_valid = 1'b1;
    vote_cand  = c;
    step();
    vote_valid = 1'b0;
    chk("vote_ready_busy", vote_ready, 0);
    chk("vote_read_no_wr", ram_wr_en, 0);
    step();
    chk("vote_wr_en", ram_wr_en, 1);
    chk("vote_addr", ram_addr, c);
    chk("vote_wdata", ram_data_in, nv);
    chk("vote_done", vote_done, 1);
    chk("vote_sat", vote_sat, sat);
    step();
    chk("vote_done_low", vote_done, 0);
    exp_cnt[c] = nv;
  endtask

  // Called at #1 after an edge with the DUT idle (result_req may already be high).
  task automatic do_scan();
    logic [DW-1:0] mx;
    int            wc;
    int            nmax;
    int            done_cnt;
    mx = '0;
    for (int i = 0; i < NC; i++) if (exp_cnt[i] > mx) mx = exp_cnt[i];
    wc   = -1;
    nmax = 0;
    for (int i = 0; i < NC; i++) begin
      if (exp_cnt[i] == mx) begin
        if (wc < 0) wc = i;
        nmax++;
      end
    end
    result_req = 1'b1;
    step();
    result_req = 1'b0;
    chk("scan_ready_low", vote_ready, 0);
    chk("scan_win_cleared", win_valid, 0);
    chk("scan_no_wr", ram_wr_en, 0);
    done_cnt = 0;
    for (int k = 0; k < NC; k++) begin
      step();
      chk("res_valid", res_valid, 1);
      chk("res_cand", res_cand, k);
      chk("res_count", res_count, exp_cnt[k]);
      if (result_done) done_cnt++;
    end
    chk("done_on_last_beat", result_done, 1);
    chk("win_valid", win_valid, 1);
    chk("win_cand", win_cand, wc);
    chk("win_count", win_count, mx);
    chk("win_tie", win_tie, (nmax > 1) ? 1 : 0);
    step();
    if (result_done) done_cnt++;
    chk("res_valid_fall", res_valid, 0);
    chk("result_done_once", done_cnt, 1);
    chk("win_valid_hold", win_valid, 1);
    chk("ready_after_scan", vote_ready, 1);
  endtask

  task automatic do_clear();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clear_ram_reset", ram_reset, 1);
    chk("clear_win_valid", win_valid, 0);
    step();
    chk("clear_ram_reset_once", ram_reset, 0);
    model_clear();
  endtask

  initial begin
    int dcnt;
    int rcnt;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    vote_valid = 1'b0;
    vote_cand  = '0;
    clear_req  = 1'b0;
    result_req = 1'b0;
    model_clear();

    // Reset state.
    step();
    step();
    chk_all_zero("rst");
    reset = 1'b0;
    chk("ready_before_first_edge", vote_ready, 0);
    step();
    chk("ready_after_reset", vote_ready, 1);

    // Clear, 3 votes for 2 and 1 for 5, then scan.
    do_clear();
    cast_vote(4'd2);
    cast_vote(4'd2);
    cast_vote(4'd2);
    cast_vote(4'd5);
    do_scan();

    // Ballot held valid for candidate 7 over 30 cycles.
    vote_valid = 1'b1;
    vote_cand  = 4'd7;
    dcnt       = 0;
    rcnt       = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (vote_done) dcnt++;
      if (vote_ready) rcnt++;
    end
    vote_valid = 1'b0;
    chk("held_done_pulses", dcnt, 10);
    chk("held_ready_cycles", rcnt, 10);
    exp_cnt[7] = exp_cnt[7] + 10'd10;
    do_scan();

    // Out-of-range candidates are rejected without touching the RAM.
    vote_valid = 1'b1;
    vote_cand  = 4'd15;
    step();
    vote_valid = 1'b0;
    chk("err15_pulse", vote_err, 1);
    chk("err15_no_wr", ram_wr_en, 0);
    chk("err15_ready", vote_ready, 1);
    step();
    chk("err15_pulse_end", vote_err, 0);
    chk("err15_no_wr2", ram_wr_en, 0);
    chk("err15_no_done", vote_done, 0);
    vote_valid = 1'b1;
    vote_cand  = 4'd12;
    step();
    vote_valid = 1'b0;
    chk("err12_pulse", vote_err, 1);
    chk("err12_no_wr", ram_wr_en, 0);
    step();
    chk("err12_pulse_end", vote_err, 0);
    chk("err12_no_wr2", ram_wr_en, 0);
    cast_vote(4'd11);

    // Saturation on candidate 4.
    for (int n = 0; n < 1022; n++) cast_vote(4'd4);
    chk("preload_1022", exp_cnt[4], 1022);
    cast_vote(4'd4);
    cast_vote(4'd4);
    cast_vote(4'd4);
    do_scan();

    // Tie between 1 and 9.
    do_clear();
    for (int n = 0; n < 5; n++) begin
      cast_vote(4'd1);
      cast_vote(4'd9);
    end
    do_scan();

    // Reset during the read phase drops the ballot.
    vote_valid = 1'b1;
    vote_cand  = 4'd3;
    step();
    vote_valid = 1'b0;
    chk("vread_addr", ram_addr, 3);
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    step();
    chk("midrst_no_wr", ram_wr_en, 0);
    chk("midrst_no_done", vote_done, 0);
    reset = 1'b0;
    step();
    chk("midrst_ready", vote_ready, 1);
    do_scan();

    // clear_req and result_req together: clear wins, then scan of zeros.
    clear_req  = 1'b1;
    result_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("both_ram_reset", ram_reset, 1);
    chk("both_win_valid", win_valid, 0);
    chk("both_no_res", res_valid, 0);
    step();
    chk("both_ram_reset_once", ram_reset, 0);
    model_clear();
    do_scan();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
